// File: rtl/sodor_dmem_bridge_pkg.sv
// rtl/sodor_dmem_bridge_pkg.sv - shared types and constants for the dmem bridge
`ifndef SIZE_OF_THE_BUS
`define SIZE_OF_THE_BUS 32
`endif

package sodor_dmem_bridge_pkg;
  localparam int BUS_W = `SIZE_OF_THE_BUS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DELAY = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic FCN_WR = 1'b1;
  localparam logic FCN_RD = 1'b0;
endpackage

// File: rtl/sodor_sat_counter.sv
// rtl/sodor_sat_counter.sv - 32-bit saturating counter with synchronous load
module sodor_sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_inc,
  output logic [31:0] o_count
);
  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_inc && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/sodor_dmem_bridge.sv
// rtl/sodor_dmem_bridge.sv - single-outstanding dmem bridge with latency injection
module sodor_dmem_bridge
  import sodor_dmem_bridge_pkg::*;
#(
  parameter int               LATENCY   = 1,
  parameter logic [BUS_W-1:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [BUS_W-1:0] ADDR_SIZE = 32'h0001_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             core_req_valid,
  output logic             core_req_ready,
  input  logic [BUS_W-1:0] core_req_addr,
  input  logic [BUS_W-1:0] core_req_data,
  input  logic             core_req_fcn,
  input  logic [2:0]       core_req_typ,
  output logic             core_resp_valid,
  output logic [BUS_W-1:0] core_resp_data,
  output logic             mem_req_valid,
  output logic [BUS_W-1:0] mem_req_addr,
  output logic [BUS_W-1:0] mem_req_data,
  output logic             mem_req_fcn,
  output logic [2:0]       mem_req_typ,
  input  logic             mem_resp_valid,
  input  logic [BUS_W-1:0] mem_resp_data,
  output logic             err_valid,
  output logic [BUS_W-1:0] err_addr,
  output logic [31:0]      req_count
);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [BUS_W-1:0] r_addr;
  logic [BUS_W-1:0] r_wdata;
  logic             r_fcn;
  logic [2:0]       r_typ;
  logic [BUS_W-1:0] r_rdata;
  logic [BUS_W-1:0] r_err_addr;
  logic [7:0]       r_cnt;
  logic             w_accept;
  logic             w_in_range;
  logic             w_capture;

  // Offset compare equals base/limit compare because the window never wraps.
  assign w_in_range     = (core_req_addr - ADDR_BASE) < ADDR_SIZE;
  assign core_req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept       = core_req_valid && core_req_ready;
  assign w_capture      = (r_state == ST_ISSUE) && mem_resp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    mem_req_valid   = 1'b0;
    core_resp_valid = 1'b0;
    core_resp_data  = '0;
    err_valid       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = w_in_range ? ST_ISSUE : ST_ERR;
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_resp_valid) w_next_state = (LATENCY == 1) ? ST_RESP : ST_DELAY;
      end
      ST_DELAY: begin
        if (r_cnt == 8'd1) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        core_resp_valid = 1'b1;
        core_resp_data  = r_rdata;
        w_next_state    = ST_IDLE;
      end
      ST_ERR: begin
        core_resp_valid = 1'b1;
        err_valid       = 1'b1;
        w_next_state    = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_fcn      <= FCN_RD;
      r_typ      <= '0;
      r_rdata    <= '0;
      r_err_addr <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= core_req_addr;
        r_wdata <= core_req_data;
        r_fcn   <= core_req_fcn;
        r_typ   <= core_req_typ;
        if (!w_in_range) r_err_addr <= core_req_addr;
      end
      if (w_capture) begin
        r_rdata <= (r_fcn == FCN_WR) ? '0 : mem_resp_data;
        r_cnt   <= LAT_M1;
      end else if (r_state == ST_DELAY) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  assign mem_req_addr = r_addr;
  assign mem_req_data = r_wdata;
  assign mem_req_fcn  = r_fcn;
  assign mem_req_typ  = r_typ;
  assign err_addr     = r_err_addr;

  sodor_sat_counter u_req_count (
    .clk        (clk),
    .rst        (rst),
    .i_load     (1'b0),
    .i_load_val (32'h0),
    .i_inc      (w_accept),
    .o_count    (req_count)
  );
endmodule

// File: tb/tb_sodor_dmem_bridge.sv
// tb/tb_sodor_dmem_bridge.sv - bench for sodor_dmem_bridge at LATENCY 1, 2 and 3
module tb_sodor_dmem_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid [3];
  logic        core_req_ready [3];
  logic [31:0] core_req_addr  [3];
  logic [31:0] core_req_data  [3];
  logic        core_req_fcn   [3];
  logic [2:0]  core_req_typ   [3];
  logic        core_resp_valid[3];
  logic [31:0] core_resp_data [3];
  logic        mem_req_valid  [3];
  logic [31:0] mem_req_addr   [3];
  logic [31:0] mem_req_data   [3];
  logic        mem_req_fcn    [3];
  logic [2:0]  mem_req_typ    [3];
  logic        mem_resp_valid [3];
  logic [31:0] mem_resp_data  [3];
  logic        err_valid      [3];
  logic [31:0] err_addr       [3];
  logic [31:0] req_count      [3];

  logic        sat_load;
  logic [31:0] sat_val;
  logic        sat_inc;
  logic [31:0] sat_count;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          mem_wait  [3];
  int          wait_cnt  [3];
  int          last_acc  [3];
  logic [31:0] ref_count [3];
  logic [31:0] mem_store [logic [33:0]];
  logic [31:0] ref_mem   [logic [33:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sodor_dmem_bridge #(
      .LATENCY   (g + 1),
      .ADDR_BASE ((g == 0) ? 32'h0000_0200 : 32'h0000_0000),
      .ADDR_SIZE ((g == 0) ? 32'h0000_1000 : 32'h0001_0000)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .core_req_valid  (core_req_valid[g]),
      .core_req_ready  (core_req_ready[g]),
      .core_req_addr   (core_req_addr[g]),
      .core_req_data   (core_req_data[g]),
      .core_req_fcn    (core_req_fcn[g]),
      .core_req_typ    (core_req_typ[g]),
      .core_resp_valid (core_resp_valid[g]),
      .core_resp_data  (core_resp_data[g]),
      .mem_req_valid   (mem_req_valid[g]),
      .mem_req_addr    (mem_req_addr[g]),
      .mem_req_data    (mem_req_data[g]),
      .mem_req_fcn     (mem_req_fcn[g]),
      .mem_req_typ     (mem_req_typ[g]),
      .mem_resp_valid  (mem_resp_valid[g]),
      .mem_resp_data   (mem_resp_data[g]),
      .err_valid       (err_valid[g]),
      .err_addr        (err_addr[g]),
      .req_count       (req_count[g])
    );
  end

  sodor_sat_counter u_sat (
    .clk        (clk),
    .rst        (rst),
    .i_load     (sat_load),
    .i_load_val (sat_val),
    .i_inc      (sat_inc),
    .o_count    (sat_count)
  );

  // Memory model: answers after mem_wait cycles, random noise on the response when idle.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      mem_resp_valid[d] = ($urandom_range(0, 3) == 0);
      mem_resp_data[d]  = $urandom;
      if (mem_req_valid[d] === 1'b1) begin
        mem_resp_valid[d] = 1'b0;
        if (wait_cnt[d] >= mem_wait[d]) begin
          mem_resp_valid[d] = 1'b1;
          if (mem_req_fcn[d]) begin
            mem_store[{d[1:0], mem_req_addr[d]}] = mem_req_data[d];
          end else if (mem_store.exists({d[1:0], mem_req_addr[d]})) begin
            mem_resp_data[d] = mem_store[{d[1:0], mem_req_addr[d]}];
          end else begin
            mem_resp_data[d] = 32'h0;
          end
          wait_cnt[d] = 0;
        end else begin
          wait_cnt[d] = wait_cnt[d] + 1;
        end
      end else begin
        wait_cnt[d] = 0;
      end
    end
  end

  function automatic bit in_win(input int d, input logic [31:0] a);
    longint base, size, av;
    base = (d == 0) ? 64'h200 : 64'h0;
    size = (d == 0) ? 64'h1000 : 64'h10000;
    av   = {32'h0, a};
    return (av >= base) && (av < base + size);
  endfunction

  task automatic do_req(input int d, input logic [31:0] a_addr, input logic [31:0] a_wd,
                        input logic a_fcn, input logic [2:0] a_typ, input int mw);
    int          n;
    int          k;
    bit          got;
    bit          err;
    bit          mv;
    int          exp_lat;
    logic [31:0] exp_data;
    logic [33:0] key;
    err     = !in_win(d, a_addr);
    key     = {d[1:0], a_addr};
    exp_lat = err ? 1 : (1 + mw + (d + 1));
    if (err || a_fcn) exp_data = 32'h0;
    else exp_data = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    mem_wait[d] = mw;
    n = 0;
    while (core_req_ready[d] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (core_req_ready[d] !== 1'b1) begin
      bad++;
      $display("FAIL ready_wait d=%0d got=%b want=1", d, core_req_ready[d]);
    end
    core_req_valid[d] = 1'b1;
    core_req_addr[d]  = a_addr;
    core_req_data[d]  = a_wd;
    core_req_fcn[d]   = a_fcn;
    core_req_typ[d]   = a_typ;
    @(negedge clk);
    last_acc[d]       = cyc;
    core_req_valid[d] = 1'b0;
    core_req_addr[d]  = $urandom;
    core_req_data[d]  = $urandom;
    core_req_fcn[d]   = 1'($urandom);
    core_req_typ[d]   = 3'($urandom);
    if (!err && a_fcn) ref_mem[key] = a_wd;
    if (ref_count[d] != 32'hFFFF_FFFF) ref_count[d] = ref_count[d] + 1;
    got = 0;
    k   = 1;
    while (!got && k <= 300) begin
      total++;
      if (core_req_ready[d] !== 1'b0) begin
        bad++;
        $display("FAIL busy_ready d=%0d k=%0d got=%b want=0", d, k, core_req_ready[d]);
      end
      mv = !err && (k <= 1 + mw);
      total++;
      if (mem_req_valid[d] !== mv) begin
        bad++;
        $display("FAIL mem_req_valid d=%0d k=%0d got=%b want=%b", d, k, mem_req_valid[d], mv);
      end
      if (mv) begin
        total++;
        if ({mem_req_addr[d], mem_req_data[d], mem_req_fcn[d], mem_req_typ[d]} !==
            {a_addr, a_wd, a_fcn, a_typ}) begin
          bad++;
          $display("FAIL mem_fields d=%0d k=%0d got=%h/%h/%b/%h want=%h/%h/%b/%h", d, k,
                   mem_req_addr[d], mem_req_data[d], mem_req_fcn[d], mem_req_typ[d],
                   a_addr, a_wd, a_fcn, a_typ);
        end
      end
      if (core_resp_valid[d] === 1'b1) begin
        got = 1;
        total++;
        if (k != exp_lat) begin
          bad++;
          $display("FAIL resp_latency d=%0d got=%0d want=%0d", d, k, exp_lat);
        end
        total++;
        if (core_resp_data[d] !== exp_data) begin
          bad++;
          $display("FAIL resp_data d=%0d addr=%h got=%h want=%h", d, a_addr, core_resp_data[d], exp_data);
        end
        total++;
        if (err_valid[d] !== err) begin
          bad++;
          $display("FAIL err_valid d=%0d addr=%h got=%b want=%b", d, a_addr, err_valid[d], err);
        end
        if (err) begin
          total++;
          if (err_addr[d] !== a_addr) begin
            bad++;
            $display("FAIL err_addr d=%0d got=%h want=%h", d, err_addr[d], a_addr);
          end
        end
        total++;
        if (req_count[d] !== ref_count[d]) begin
          bad++;
          $display("FAIL req_count d=%0d got=%h want=%h", d, req_count[d], ref_count[d]);
        end
      end else begin
        total++;
        if (core_resp_data[d] !== 32'h0 || err_valid[d] !== 1'b0) begin
          bad++;
          $display("FAIL quiet_out d=%0d k=%0d data=%h err=%b want 0/0", d, k, core_resp_data[d], err_valid[d]);
        end
      end
      if (!got) begin
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL resp_timeout d=%0d addr=%h got=none want=response", d, a_addr);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) ref_count[d] = 32'h0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({mem_req_valid[d], mem_req_addr[d], mem_req_data[d], mem_req_fcn[d], mem_req_typ[d],
           core_resp_valid[d], core_resp_data[d], err_valid[d], err_addr[d], req_count[d],
           core_req_ready[d]} !== '0) begin
        bad++;
        $display("FAIL reset_outputs d=%0d got nonzero want all 0 (ready=%b count=%h)", d,
                 core_req_ready[d], req_count[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (core_req_ready[d] !== 1'b1 || req_count[d] !== 32'h0) begin
        bad++;
        $display("FAIL reset_release d=%0d ready=%b count=%h want 1/0", d, core_req_ready[d], req_count[d]);
      end
    end
  endtask

  task automatic test_read_latency();
    mem_store[{2'd2, 32'h100}] = 32'hDEAD_BEEF;
    ref_mem[{2'd2, 32'h100}]   = 32'hDEAD_BEEF;
    do_req(2, 32'h100, 32'h0, 1'b0, 3'b010, 0);
  endtask

  task automatic test_write_readback();
    do_req(0, 32'h200, 32'h1234_5678, 1'b1, 3'b010, 0);
    do_req(0, 32'h200, 32'h0, 1'b0, 3'b010, 0);
  endtask

  task automatic test_out_of_range();
    do_req(2, 32'h0002_0000, 32'h0, 1'b0, 3'b010, 0);
    do_req(1, 32'h0000_FFFF, 32'h0, 1'b0, 3'b000, 0);
    do_req(1, 32'h0001_0000, 32'h0, 1'b0, 3'b000, 0);
    do_req(1, 32'hFFFF_FFFF, 32'h0, 1'b1, 3'b000, 0);
    do_req(0, 32'h0000_01FC, 32'h0, 1'b0, 3'b010, 0);
    do_req(0, 32'h0000_11FF, 32'h0, 1'b0, 3'b000, 0);
    do_req(0, 32'h0000_1200, 32'h0, 1'b0, 3'b000, 0);
  endtask

  task automatic test_mem_stall();
    do_req(2, 32'h104, 32'hCAFE_F00D, 1'b1, 3'b010, 2);
    do_req(2, 32'h104, 32'h0, 1'b0, 3'b010, 2);
  endtask

  task automatic test_reset_mid();
    mem_wait[2] = 0;
    core_req_valid[2] = 1'b1;
    core_req_addr[2]  = 32'h40;
    core_req_data[2]  = 32'h0;
    core_req_fcn[2]   = 1'b0;
    core_req_typ[2]   = 3'b010;
    @(negedge clk);
    core_req_valid[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({mem_req_valid[d], mem_req_addr[d], mem_req_data[d], mem_req_fcn[d], mem_req_typ[d],
           core_resp_valid[d], core_resp_data[d], err_valid[d], err_addr[d], req_count[d],
           core_req_ready[d]} !== '0) begin
        bad++;
        $display("FAIL midreset_outputs d=%0d got nonzero want all 0 (count=%h)", d, req_count[d]);
      end
    end
    rst = 1'b0;
    for (int d = 0; d < 3; d++) ref_count[d] = 32'h0;
    repeat (6) begin
      @(negedge clk);
      total++;
      if (core_resp_valid[2] !== 1'b0) begin
        bad++;
        $display("FAIL midreset_noresp got=%b want=0", core_resp_valid[2]);
      end
    end
    total++;
    if (req_count[2] !== 32'h0) begin
      bad++;
      $display("FAIL midreset_count got=%h want=0", req_count[2]);
    end
    do_req(2, 32'h100, 32'h0, 1'b0, 3'b010, 0);
  endtask

  task automatic test_back_to_back();
    int prev;
    pulse_reset();
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      do_req(1, 32'h400 + 32'(4 * i), 32'h0, 1'b0, 3'b010, 0);
      if (i > 0) begin
        total++;
        if (last_acc[1] - prev != 4) begin
          bad++;
          $display("FAIL b2b_spacing i=%0d got=%0d want=4", i, last_acc[1] - prev);
        end
      end
      prev = last_acc[1];
    end
    @(negedge clk);
    total++;
    if (req_count[1] !== 32'd10) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=10", req_count[1]);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    sat_load = 1'b1;
    sat_val  = 32'hFFFF_FFFE;
    @(negedge clk);
    sat_load = 1'b0;
    sat_inc  = 1'b1;
    @(negedge clk);
    total++;
    if (sat_count !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL sat_reach got=%h want=ffffffff", sat_count);
    end
    repeat (3) @(negedge clk);
    total++;
    if (sat_count !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL sat_hold got=%h want=ffffffff", sat_count);
    end
    sat_inc = 1'b0;
  endtask

  task automatic test_random();
    int          d;
    logic [31:0] base;
    logic [31:0] size;
    logic [31:0] a;
    for (int i = 0; i < 30; i++) begin
      d    = $urandom_range(0, 2);
      base = (d == 0) ? 32'h200 : 32'h0;
      size = (d == 0) ? 32'h1000 : 32'h10000;
      if ($urandom_range(0, 3) == 0) a = base + size + 32'(4 * $urandom_range(0, 3));
      else a = base + 32'(4 * $urandom_range(0, 7));
      do_req(d, a, $urandom, 1'($urandom_range(0, 1)), 3'($urandom), $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst      = 1'b1;
    sat_load = 1'b0;
    sat_val  = 32'h0;
    sat_inc  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      core_req_valid[d] = 1'b0;
      core_req_addr[d]  = 32'h0;
      core_req_data[d]  = 32'h0;
      core_req_fcn[d]   = 1'b0;
      core_req_typ[d]   = 3'b0;
      mem_resp_valid[d] = 1'b0;
      mem_resp_data[d]  = 32'h0;
      mem_wait[d]       = 0;
      wait_cnt[d]       = 0;
      last_acc[d]       = 0;
      ref_count[d]      = 32'h0;
    end
    test_reset();
    test_read_latency();
    test_write_readback();
    test_out_of_range();
    test_mem_stall();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
